// File: rtl/logic_sweep_sequencer_pkg.sv
// rtl/logic_sweep_sequencer_pkg.sv - shared types, sizes and truth-table helper for the logic sweep sequencer
package sweep_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_t;

    // Table bit for vector idx; vector 0 lives in the MSB of the table.
    function automatic logic tt_bit(input logic [NUM_VEC-1:0] tbl, input logic [VEC_W-1:0] idx);
        logic [VEC_W-1:0] pos;
        pos = VEC_W'(NUM_VEC - 1) - idx;
        return tbl[pos];
    endfunction

endpackage

// File: rtl/logic_sweep_sequencer_if.sv
// rtl/logic_sweep_sequencer_if.sv - control/result bundle between the test controller and the sweep sequencer
interface logic_sweep_sequencer_if;
    import sweep_pkg::*;

    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_VEC-1:0] observed_table;
    logic [NUM_VEC-1:0] mismatch_mask;
    logic [NUM_VEC-1:0] unstable_mask;

    modport master (
        output start, abort,
        input  busy, done, pass, observed_table, mismatch_mask, unstable_mask
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, observed_table, mismatch_mask, unstable_mask
    );

endinterface

// File: rtl/logic_sweep_sequencer_sync_2ff.sv
// rtl/logic_sweep_sequencer_sync_2ff.sv - two-flop synchroniser for the asynchronous design output
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/logic_sweep_sequencer.sv
// rtl/logic_sweep_sequencer.sv - drives all 16 input vectors into a 4-in/1-out gate design and records its truth table
module logic_sweep_sequencer
    import sweep_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE   = 16'h47FD,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLES       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    logic_sweep_sequencer_if.slave  ctrl,
    output logic                    drv_in1,
    output logic                    drv_in2,
    output logic                    drv_in3,
    output logic                    drv_in4,
    input  logic                    dut_out
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       SAMPLE_LOAD = 4'(SAMPLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

    sweep_state_t       state_q,      state_d;
    logic [VEC_W-1:0]   vec_q,        vec_d;
    logic [VEC_W-1:0]   drv_q,        drv_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [3:0]         sample_cnt_q, sample_cnt_d;
    logic               ref_q,        ref_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               pass_q,       pass_d;
    logic [NUM_VEC-1:0] observed_q,   observed_d;
    logic [NUM_VEC-1:0] unstable_q,   unstable_d;

    logic               sync_out;
    logic [VEC_W-1:0]   bit_pos;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (dut_out),
        .q_o (sync_out)
    );

    // Result tables are indexed MSB-first by vector number.
    assign bit_pos = LAST_VEC - vec_q;

    // State and datapath registers; reset discards any partial sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            drv_q        <= '0;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            ref_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            observed_q   <= '0;
            unstable_q   <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            drv_q        <= drv_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            ref_q        <= ref_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            observed_q   <= observed_d;
            unstable_q   <= unstable_d;
        end
    end

    // Next-state logic: settle, take a reference sample, then check it stays put for SAMPLES cycles.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        drv_d        = drv_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        ref_d        = ref_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        observed_d   = observed_q;
        unstable_d   = unstable_q;

        if (state_q != ST_IDLE && ctrl.abort) begin
            // Partial tables are kept for debug; pass is never raised by an aborted sweep.
            state_d = ST_IDLE;
            drv_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl.start) begin
                        state_d      = ST_SETTLE;
                        vec_d        = '0;
                        drv_d        = '0;
                        settle_cnt_d = SETTLE_LOAD;
                        busy_d       = 1'b1;
                        pass_d       = 1'b0;
                        observed_d   = '0;
                        unstable_d   = '0;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_d      = ST_SAMPLE;
                        sample_cnt_d = SAMPLE_LOAD;
                        ref_d        = sync_out;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    if (sync_out != ref_q) begin
                        unstable_d[bit_pos] = 1'b1;
                    end
                    if (sample_cnt_q == '0) begin
                        observed_d[bit_pos] = ref_q;
                        if (vec_q == LAST_VEC) begin
                            // Drive regs hold the last vector so the design is left in a known state.
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (observed_d == TRUTH_TABLE) && (unstable_d == '0);
                        end else begin
                            state_d      = ST_SETTLE;
                            vec_d        = vec_q + 1'b1;
                            drv_d        = vec_q + 1'b1;
                            settle_cnt_d = SETTLE_LOAD;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q - 1'b1;
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign drv_in1 = drv_q[3];
    assign drv_in2 = drv_q[2];
    assign drv_in3 = drv_q[1];
    assign drv_in4 = drv_q[0];

    assign ctrl.busy           = busy_q;
    assign ctrl.done           = done_q;
    assign ctrl.pass           = pass_q;
    assign ctrl.observed_table = observed_q;
    assign ctrl.unstable_mask  = unstable_q;
    assign ctrl.mismatch_mask  = observed_q ^ TRUTH_TABLE;

endmodule
